// File: rtl/spi_loader_pkg.sv
// Shared types and constants for the SPI program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } loader_state_e;

    // Number of bytes in the little-endian length field of a frame.
    localparam int LEN_BYTES = 4;

endpackage

// File: rtl/spi_word_loader_word_packer.sv
// Packs a byte stream into DATA_W-bit little-endian words with byte enables.
// Latency: word/be/word_valid registered, one cycle after the completing byte.
// Backpressure: none; accepts a byte every cycle, output is a one-cycle strobe.
module word_packer #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clear,
    input  logic [7:0]          in_byte,
    input  logic                in_valid,
    input  logic                in_last,
    output logic [DATA_W-1:0]   word,
    output logic [DATA_W/8-1:0] be,
    output logic                word_valid
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANE_W-1:0]  lane_q;
    logic [DATA_W-1:0]  acc_q;
    logic [LANES-1:0]   acc_be_q;
    logic [DATA_W-1:0]  acc_nxt;
    logic [LANES-1:0]   be_nxt;
    logic               lane_full;
    logic               emit;

    // Merge the incoming byte into its lane and decide whether the word is complete.
    always_comb begin
        acc_nxt = acc_q;
        be_nxt  = acc_be_q;
        acc_nxt[{lane_q, 3'b000} +: 8] = in_byte;
        be_nxt[lane_q]                 = 1'b1;
        lane_full = (lane_q == LANE_W'(LANES - 1));
        emit      = in_valid && (lane_full || in_last);
    end

    // Lane accumulator; output regs are zero whenever no word is being presented.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_q     <= '0;
            acc_q      <= '0;
            acc_be_q   <= '0;
            word       <= '0;
            be         <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            lane_q     <= '0;
            acc_q      <= '0;
            acc_be_q   <= '0;
            word       <= '0;
            be         <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= emit;
            word       <= emit ? acc_nxt : '0;
            be         <= emit ? be_nxt  : '0;
            if (in_valid) begin
                if (emit) begin
                    lane_q   <= '0;
                    acc_q    <= '0;
                    acc_be_q <= '0;
                end else begin
                    lane_q   <= lane_q + LANE_W'(1);
                    acc_q    <= acc_nxt;
                    acc_be_q <= be_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/spi_word_loader.sv
// Parses MAGIC/len/payload[/checksum] frames from the SPI byte stream into memory writes.
// Latency: write strobe one cycle after the byte completing a word; optional checksum via SPI_LOADER_CHECKSUM_EN.
// Backpressure: none; accepts a byte every cycle, core held in reset while loading or failed.
module spi_word_loader
    import spi_loader_pkg::*;
#(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int unsigned        MAX_BYTES = 65536,
    parameter logic [7:0]         MAGIC     = 8'hA5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                load_program,
    input  logic [7:0]          rx_byte,
    input  logic                rx_valid,
    output logic                core_program_resetn,
    output logic [ADDR_W-1:0]   mem_write_addr,
    output logic [DATA_W-1:0]   mem_write_data,
    output logic [DATA_W/8-1:0] mem_write_be,
    output logic                mem_write_en,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [31:0]         bytes_loaded
);

    localparam int BPW = DATA_W / 8;

`ifdef SPI_LOADER_CHECKSUM_EN
    localparam loader_state_e AFTER_PAYLOAD = CHECK;
`else
    localparam loader_state_e AFTER_PAYLOAD = DONE;
`endif

    loader_state_e state_q, state_d;
    logic          load_q;
    logic [31:0]   len_q;
    logic [31:0]   len_asm;
    logic [1:0]    len_idx_q;
    logic          len_take;
    logic          pay_take;
    logic          pay_last;
    logic          clear;
    logic [31:0]   word_off;
`ifdef SPI_LOADER_CHECKSUM_EN
    logic [7:0]    sum_q;
`endif

    // Length word as it would read after merging the current byte.
    always_comb begin
        len_asm = len_q;
        len_asm[{len_idx_q, 3'b000} +: 8] = rx_byte;
    end

    assign pay_last = ((bytes_loaded + 32'd1) == len_q);
    assign word_off = bytes_loaded & ~(32'(BPW - 1));

    // Next-state and per-byte strobes; dropping load_program mid-frame is a failed load.
    always_comb begin
        state_d  = state_q;
        len_take = 1'b0;
        pay_take = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_program) state_d = SYNC;
            end
            SYNC: begin
                if (!load_program)                          state_d = IDLE;
                else if (rx_valid && (rx_byte == MAGIC))    state_d = LEN;
            end
            LEN: begin
                if (!load_program) begin
                    state_d = ERROR;
                end else if (rx_valid) begin
                    len_take = 1'b1;
                    if (len_idx_q == 2'(LEN_BYTES - 1)) begin
                        if (len_asm > 32'(MAX_BYTES)) state_d = ERROR;
                        else if (len_asm == 32'd0)    state_d = AFTER_PAYLOAD;
                        else                          state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (!load_program) begin
                    state_d = ERROR;
                end else if (rx_valid) begin
                    pay_take = 1'b1;
                    if (pay_last) state_d = AFTER_PAYLOAD;
                end
            end
`ifdef SPI_LOADER_CHECKSUM_EN
            CHECK: begin
                if (!load_program)  state_d = ERROR;
                else if (rx_valid)  state_d = (rx_byte == sum_q) ? DONE : ERROR;
            end
`endif
            DONE: begin
                if (!load_program) state_d = IDLE;
            end
            ERROR: begin
                if (load_program && !load_q) state_d = SYNC;
            end
            default: state_d = IDLE;
        endcase
        clear = (state_d == SYNC) && (state_q != SYNC);
    end

    // State register and load_program history for the ERROR retry edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_program;
        end
    end

    // Frame counters; cleared on every entry to SYNC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q          <= '0;
            len_idx_q      <= '0;
            bytes_loaded   <= '0;
            mem_write_addr <= '0;
        end else if (clear) begin
            len_q          <= '0;
            len_idx_q      <= '0;
            bytes_loaded   <= '0;
        end else begin
            if (len_take) begin
                len_q     <= len_asm;
                len_idx_q <= len_idx_q + 2'd1;
            end
            if (pay_take) begin
                bytes_loaded   <= bytes_loaded + 32'd1;
                mem_write_addr <= BASE_ADDR + ADDR_W'(word_off);
            end
        end
    end

`ifdef SPI_LOADER_CHECKSUM_EN
    // Running mod-256 sum of payload bytes, compared against the trailer in CHECK.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          sum_q <= '0;
        else if (clear)     sum_q <= '0;
        else if (pay_take)  sum_q <= sum_q + rx_byte;
    end
`endif

    word_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (clear),
        .in_byte    (rx_byte),
        .in_valid   (pay_take),
        .in_last    (pay_last),
        .word       (mem_write_data),
        .be         (mem_write_be),
        .word_valid (mem_write_en)
    );

    // Status decode; the core stays in reset while loading or after a failed load.
    always_comb begin
        busy  = (state_q == SYNC) || (state_q == LEN) ||
                (state_q == PAYLOAD) || (state_q == CHECK);
        done  = (state_q == DONE);
        error = (state_q == ERROR);
        core_program_resetn = !(load_program || (state_q == ERROR));
    end

endmodule

// File: tb/tb_spi_word_loader.sv
// Scoreboard bench for spi_word_loader: expected writes queued at stimulus time, popped on mem_write_en.
// Latency: checks writes on the falling edge after each strobe.
// Backpressure: none; bytes driven back-to-back and with gaps.
module tb_spi_word_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        load_program = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        core_program_resetn;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_be;
    logic        mem_write_en;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] bytes_loaded;

    int  checks = 0;
    int  errors = 0;
    int  idle_bad = 0;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    spi_word_loader #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .BASE_ADDR (32'h0000_0100),
        .MAX_BYTES (65536),
        .MAGIC     (8'hA5)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .load_program        (load_program),
        .rx_byte             (rx_byte),
        .rx_valid            (rx_valid),
        .core_program_resetn (core_program_resetn),
        .mem_write_addr      (mem_write_addr),
        .mem_write_data      (mem_write_data),
        .mem_write_be        (mem_write_be),
        .mem_write_en        (mem_write_en),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .bytes_loaded        (bytes_loaded)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_write_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {mem_write_addr, mem_write_data}, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", mem_write_addr, e.addr);
                chk("wr_data", mem_write_data, e.data);
                chk("wr_be",   mem_write_be,   e.be);
            end
        end else if (mem_write_data != 32'd0 || mem_write_be != 4'd0) begin
            idle_bad++;
        end
    end

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.be   = b;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [31:0] len);
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
    endtask

    task automatic trailer(input logic [7:0] s);
`ifdef SPI_LOADER_CHECKSUM_EN
        send_byte(s);
`else
        if (s == 8'hFF) idle(1);
`endif
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_core_resetn", core_program_resetn, 1);
        chk("rst_busy", busy, 0);
        chk("rst_write_en", mem_write_en, 0);
        chk("rst_bytes_loaded", bytes_loaded, 0);
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        // Test 1: two full words, back-to-back bytes
        load_program = 1'b1;
        idle(2);
        chk("t1_busy_sync", busy, 1);
        chk("t1_core_held", core_program_resetn, 0);
        push_wr(32'h100, 32'h4433_2211, 4'hF);
        push_wr(32'h104, 32'h8877_6655, 4'hF);
        send_hdr(32'd8);
        for (int i = 1; i <= 8; i++) send_byte(8'(i * 8'h11));
        trailer(8'h64);
        idle(3);
        chk("t1_done", done, 1);
        chk("t1_bytes_loaded", bytes_loaded, 8);
        chk("t1_core_held_done", core_program_resetn, 0);
        load_program = 1'b0;
        idle(2);
        chk("t1_done_cleared", done, 0);
        chk("t1_core_released", core_program_resetn, 1);

        // Test 2: partial final word, bytes with gaps
        load_program = 1'b1;
        idle(2);
        push_wr(32'h100, 32'h0403_0201, 4'hF);
        push_wr(32'h104, 32'h0000_0005, 4'h1);
        send_hdr(32'd5);
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i));
            idle(1);
        end
        trailer(8'h0F);
        idle(3);
        chk("t2_done", done, 1);
        chk("t2_bytes_loaded", bytes_loaded, 5);
        load_program = 1'b0;
        idle(2);

        // Test 3: junk before magic, zero-length frame
        load_program = 1'b1;
        idle(2);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_hdr(32'd0);
        trailer(8'h00);
        idle(3);
        chk("t3_done", done, 1);
        chk("t3_bytes_loaded", bytes_loaded, 0);
        load_program = 1'b0;
        idle(2);

        // Test 4: oversize length, then retry via a new load_program edge
        load_program = 1'b1;
        idle(2);
        send_hdr(32'd65537);
        idle(3);
        chk("t4_error", error, 1);
        chk("t4_busy", busy, 0);
        load_program = 1'b0;
        idle(2);
        chk("t4_core_held_err", core_program_resetn, 0);
        chk("t4_error_hold", error, 1);
        load_program = 1'b1;
        idle(2);
        chk("t4_retry_busy", busy, 1);
        chk("t4_retry_error", error, 0);
        load_program = 1'b0;
        idle(2);
        chk("t4_idle_busy", busy, 0);

        // Test 5: abort mid-payload, then async reset mid-payload
        load_program = 1'b1;
        idle(2);
        send_hdr(32'd8);
        for (int i = 1; i <= 3; i++) send_byte(8'(i));
        idle(2);
        load_program = 1'b0;
        idle(3);
        chk("t5_abort_error", error, 1);
        chk("t5_abort_bytes", bytes_loaded, 3);
        send_byte(8'h44);
        send_byte(8'h55);
        idle(3);
        load_program = 1'b1;
        idle(2);
        chk("t5_resync_bytes", bytes_loaded, 0);
        chk("t5_resync_busy", busy, 1);
        send_hdr(32'd8);
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(1);
        chk("t5_pre_rst_bytes", bytes_loaded, 2);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_bytes", bytes_loaded, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_error", error, 0);
        chk("t5_rst_write_en", mem_write_en, 0);
        chk("t5_rst_addr", mem_write_addr, 0);
        @(negedge clk);
        rstn = 1'b1;
        load_program = 1'b0;
        idle(3);

`ifdef SPI_LOADER_CHECKSUM_EN
        // Test 6: checksum good, then bad
        load_program = 1'b1;
        idle(2);
        push_wr(32'h100, 32'h0003_0201, 4'h7);
        send_hdr(32'd3);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h06);
        idle(3);
        chk("t6_good_done", done, 1);
        load_program = 1'b0;
        idle(2);
        load_program = 1'b1;
        idle(2);
        push_wr(32'h100, 32'h0003_0201, 4'h7);
        send_hdr(32'd3);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h07);
        idle(3);
        chk("t6_bad_error", error, 1);
        load_program = 1'b0;
        idle(2);
        chk("t6_bad_core_held", core_program_resetn, 0);
`endif

        idle(3);
        chk("sb_empty", exp_q.size(), 0);
        chk("idle_bus_zero", idle_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_word_loader.md
Name: spi_word_loader

Overview:
Parametrised successor to the byte-wide SPI program loader. It consumes the byte stream from spi_slave and parses a framed transfer: magic byte, 32-bit length, payload, and an optional checksum. It packs the payload into DATA_W-bit words with byte enables and writes them to instruction/data memory starting at BASE_ADDR. It also holds the core in reset during the load, and reports busy, done and error status.

Parameters:
DATA_W, 32, memory write width in bits; must be a multiple of 8, range 8..64
ADDR_W, 32, memory address width
BASE_ADDR, 32'h0000_0000, byte address of the first payload byte
MAX_BYTES, 65536, largest accepted payload length in bytes
MAGIC, 8'hA5, frame start byte

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
load_program  in  1  level; high = loader owns memory and core is held in reset
rx_byte  in  8  byte from spi_slave
rx_valid  in  1  one-cycle strobe qualifying rx_byte
core_program_resetn  out  1  active-low core reset
mem_write_addr  out  ADDR_W  byte address of the word being written, aligned to DATA_W/8
mem_write_data  out  DATA_W  packed word, little-endian (first byte in bits [7:0])
mem_write_be  out  DATA_W/8  byte enables
mem_write_en  out  1  one-cycle write strobe
busy  out  1  high in states SYNC, LEN, PAYLOAD, CHECK
done  out  1  high in state DONE
error  out  1  high in state ERROR
bytes_loaded  out  32  count of payload bytes accepted in the current frame

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE; all registered outputs 0.
  - core_program_resetn = ~load_program | reset, so it reads 1 while load_program is low.
- States and transitions:
  - IDLE: load_program=1 -> SYNC.
  - SYNC: rx_valid with rx_byte==MAGIC -> LEN; any other byte is ignored.
  - LEN: capture 4 bytes, LSB first, into len.
    - On the 4th byte: len>MAX_BYTES -> ERROR; len==0 -> CHECK (feature on) or DONE (feature off); otherwise -> PAYLOAD.
  - PAYLOAD: each rx_valid byte goes into byte lane bytes_loaded mod (DATA_W/8); bytes_loaded increments.
    - A word is emitted when its last lane fills, or on byte number len (the final byte, partial word).
    - After the final byte -> CHECK (feature on) or DONE (feature off).
  - CHECK: described under Optional Feature.
  - DONE: hold until load_program=0 -> IDLE.
  - ERROR: hold; a new load_program rising edge -> SYNC. All counters clear on every entry to SYNC.
- Abort: load_program falls in LEN, PAYLOAD or CHECK -> ERROR; load_program falls in SYNC -> IDLE.
- Write timing:
  - mem_write_en pulses for exactly one cycle, in the cycle after the rx_valid that completes the word; addr, data and be are valid in that same cycle.
  - mem_write_addr = BASE_ADDR + word_index*(DATA_W/8).
  - mem_write_be for a partial final word has the low k bits set, k = bytes in that word; unused lanes are 0.
  - mem_write_data and mem_write_be are 0 whenever mem_write_en=0.
- Byte-rate limit: back-to-back rx_valid on consecutive cycles must be accepted with no loss. Never write more than len bytes.
- Core reset: core_program_resetn = 0 while load_program=1 or state==ERROR, else 1. The core never runs from a failed load.
- Arithmetic: bytes_loaded and len are 32-bit unsigned. Address arithmetic wraps modulo 2^ADDR_W.
- Bytes arriving in DONE or ERROR are ignored.

Optional Feature:
Macro: SPI_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of payload bytes is kept.
  - State CHECK consumes one extra rx byte: equal to the sum -> DONE, else -> ERROR.
  - Words already written are not rolled back; the core stays in reset via ERROR.
- Not defined: CHECK state and sum register are absent; the final payload byte (or len==0) goes directly to DONE.

Decomposition:
- Package spi_loader_pkg: loader_state_e enum (IDLE, SYNC, LEN, PAYLOAD, CHECK, DONE, ERROR); LEN_BYTES=4 constant.
- One natural sub-module: word_packer.
  - Lane accumulator plus byte-enable builder.
  - Inputs: byte, valid, last.
  - Outputs: word, be, word_valid.
- The FSM and counters stay in the top level. spi_slave stays instantiated outside, as today.

Test Plan:
1. DATA_W=32, BASE_ADDR=0x100, stream A5 08 00 00 00 11 22 33 44 55 66 77 88 -> writes (0x100, 0x44332211, be=F), (0x104, 0x88776655, be=F); done=1; core_program_resetn=0 until load_program drops, then 1.
2. len=5, payload 01..05 -> second write at 0x104, data=0x00000005, be=0001; bytes_loaded=5.
3. Junk bytes 00 FF before A5, then len=0 -> no writes; done=1 (feature off).
4. len=MAX_BYTES+1 -> error=1, no writes, core_program_resetn stays 0 after load_program falls; raising load_program again -> SYNC, error=0.
5. load_program dropped after 3 of 8 payload bytes -> error=1, no further mem_write_en; rstn pulsed low asynchronously mid-PAYLOAD -> all outputs 0 immediately, state IDLE.
6. SPI_LOADER_CHECKSUM_EN, payload 01 02 03, trailer 06 -> done=1; same payload with trailer 07 -> error=1, core held in reset.
